// File: rtl/vga_reader_pkg.sv
// Shared constants and types for the VGA pixel-buffer scanout block.
// Holds the 640x480@60 timing geometry, frame-buffer dimensions, the
// scanout state type and the RGB332 -> RGB888 colour expansion.
package vga_reader_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_DEPTH  = 307200;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned CNT_W     = 10;

  typedef enum logic {IDLE, SCAN} state_t;

  // Replicate the high bits of each RGB332 field to fill 8 bits.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            {4{d[1:0]}}};
  endfunction

endpackage

// File: rtl/vga_buffer_reader_timing.sv
// vga_timing_gen: free-running horizontal/vertical raster counters.
// Ports:
//   clk, reset     - pixel clock, synchronous active-high reset
//   hsync_n        - raw horizontal sync (active low) for the current count
//   vsync_n        - raw vertical sync (active low) for the current count
//   visible_nxt    - the position the counters move to next is visible
//   frame_first    - counters are at h=0, v=0
//   frame_last     - counters are at the last position of the frame
module vga_timing_gen
  import vga_reader_pkg::*;
#(
  parameter int unsigned H_VIS = H_VISIBLE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_VIS = V_VISIBLE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic clk,
  input  logic reset,
  output logic hsync_n,
  output logic vsync_n,
  output logic visible_nxt,
  output logic frame_first,
  output logic frame_last
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VIS + H_FP + H_SW);
  localparam logic [CNT_W-1:0] H_VE   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VIS + V_FP + V_SW);
  localparam logic [CNT_W-1:0] V_VE   = CNT_W'(V_VIS);

  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;

  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign hsync_n     = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vsync_n     = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign visible_nxt = (h_nxt < H_VE) && (v_nxt < V_VE);
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_buffer_reader.sv
// vga_buffer_reader: scans an RGB332 pixel buffer out to a VGA DAC.
// Ports:
//   clk, reset           - pixel clock, synchronous active-high reset
//   enable               - scanout request, sampled at the frame boundary
//   address2/chipselect2 - pixel-buffer read port (1-cycle read latency)
//   clken2/write2/writedata2 - port-2 controls, constant read-only use
//   readdata2            - RGB332 pixel byte for the previous address
//   vga_r/g/b            - expanded colour, zero while blanked
//   vga_hs_n/vga_vs_n    - active-low syncs aligned with colour
//   vga_blank_n          - high only for scanned visible pixels
//   frame_start          - one-cycle pulse aligned with pixel (0,0)
module vga_buffer_reader
  import vga_reader_pkg::*;
#(
  parameter int unsigned H_VIS = H_VISIBLE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_VIS = V_VISIBLE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] address2,
  output logic              chipselect2,
  output logic              clken2,
  output logic              write2,
  output logic [7:0]        writedata2,
  input  logic [7:0]        readdata2,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs_n,
  output logic              vga_vs_n,
  output logic              vga_blank_n,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_VIS * V_VIS - 1);

  logic   hs_raw_n, vs_raw_n, vis_nxt, frame_first, frame_last;
  state_t state, state_nxt;
  logic   hs1_n, vs1_n, de1, fs1;

  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .hsync_n    (hs_raw_n),
    .vsync_n    (vs_raw_n),
    .visible_nxt(vis_nxt),
    .frame_first(frame_first),
    .frame_last (frame_last)
  );

  assign clken2     = 1'b1;
  assign write2     = 1'b0;
  assign writedata2 = '0;

  // Mode only changes across the frame boundary, so a frame is never torn.
  always_comb begin
    state_nxt = state;
    if (frame_last) state_nxt = enable ? SCAN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      chipselect2 <= 1'b0;
      address2    <= '0;
      hs1_n       <= 1'b1;
      vs1_n       <= 1'b1;
      de1         <= 1'b0;
      fs1         <= 1'b0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      state <= state_nxt;
      // Strobe is registered from the lookahead position so that it is
      // valid in the same cycle the counters hold that position.
      chipselect2 <= (state_nxt == SCAN) && vis_nxt;
      // The address register is the current read address: advance after
      // each read, hold through blanking and on the last pixel, clear at
      // the frame boundary.
      if (frame_last)
        address2 <= '0;
      else if (chipselect2 && (address2 != LAST_ADDR))
        address2 <= address2 + 1'b1;
      // Stage 1: read data arrives from the buffer this cycle.
      hs1_n <= hs_raw_n;
      vs1_n <= vs_raw_n;
      de1   <= chipselect2;
      fs1   <= frame_first;
      // Stage 2: colour captured alongside the delayed sync/blank.
      vga_hs_n    <= hs1_n;
      vga_vs_n    <= vs1_n;
      vga_blank_n <= de1;
      frame_start <= fs1;
      {vga_r, vga_g, vga_b} <= de1 ? expand_rgb332(readdata2) : '0;
    end
  end

endmodule

// File: tb/tb_vga_buffer_reader.sv
// Directed testbench for vga_buffer_reader on a reduced 29x19 raster
// (visible 20x14, hsync at h=22..25, vsync at v=15..16, 551 cycles/frame).
// The buffer model returns address[7:0] one cycle after the address.
module tb_vga_buffer_reader;

  localparam int HT    = 29;
  localparam int VT    = 19;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [18:0] address2;
  logic        chipselect2, clken2, write2;
  logic [7:0]  writedata2, readdata2;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs_n, vga_vs_n, vga_blank_n, frame_start;

  logic [18:0] mem_addr_q = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tracking = 1'b0;

  always #5 clk = ~clk;

  vga_buffer_reader #(
    .H_VIS(20), .H_FP(2), .H_SW(4), .H_BP(3),
    .V_VIS(14), .V_FP(1), .V_SW(2), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .address2(address2), .chipselect2(chipselect2), .clken2(clken2),
    .write2(write2), .writedata2(writedata2), .readdata2(readdata2),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n),
    .vga_blank_n(vga_blank_n), .frame_start(frame_start)
  );

  always @(posedge clk) mem_addr_q <= address2;
  assign readdata2 = mem_addr_q[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int p, hh, vv;
    @(posedge clk);
    #1;
    cyc++;
    if (tracking) begin
      p  = cyc % FRAME;
      hh = p % HT;
      vv = p / HT;
      checks++;
      assert (!chipselect2 || (hh < 20 && vv < 14)) else begin
        errors++;
        $error("FAIL cs_in_blank: observed cs=%0b at h=%0d v=%0d expected 0", chipselect2, hh, vv);
      end
    end
    checks++;
    assert (address2 < 19'd280) else begin
      errors++;
      $error("FAIL addr_range: observed=%0d expected <280", address2);
    end
  endtask

  task automatic goto(input int target);
    if (target < cyc) chk("goto_order", 32'(cyc), 32'(target));
    while (cyc < target) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hs"},    32'(vga_hs_n), 1);
    chk({tag, "_vs"},    32'(vga_vs_n), 1);
    chk({tag, "_blank"}, 32'(vga_blank_n), 0);
    chk({tag, "_rgb"},   {8'h0, vga_r, vga_g, vga_b}, 0);
    chk({tag, "_cs"},    32'(chipselect2), 0);
    chk({tag, "_addr"},  32'(address2), 0);
    chk({tag, "_fs"},    32'(frame_start), 0);
  endtask

  initial begin
    int n_a, n_b;
    int n;

    // Reset state
    repeat (3) tick();
    chk_reset_outputs("rst");
    chk("clken2", 32'(clken2), 1);
    chk("write2", 32'(write2), 0);
    chk("writedata2", 32'(writedata2), 0);

    // Release: counters are at (0,0) in this cycle
    reset = 1'b0;
    cyc = 0;
    tracking = 1'b1;

    // Frame 0 is IDLE even with enable=1; frame_start still pulses
    goto(2);  chk("f0_fs", 32'(frame_start), 1);
    goto(3);  chk("f0_fs_low", 32'(frame_start), 0);
    n_a = 0; n_b = 0;
    while (cyc < 550) begin
      tick();
      if (vga_blank_n) n_a++;
      if (chipselect2) n_b++;
    end
    chk("f0_blank_high_count", 32'(n_a), 0);
    chk("f0_cs_count", 32'(n_b), 0);

    // Frame 1 scans
    goto(551); chk("f1_cs00", 32'(chipselect2), 1); chk("f1_addr00", 32'(address2), 0);
    goto(553); chk("f1_fs", 32'(frame_start), 1); chk("f1_blank00", 32'(vga_blank_n), 1);
    goto(556); chk("f1_addr50", 32'(address2), 5);
    goto(558);
    chk("rgb_05_r", 32'(vga_r), 32'h00);
    chk("rgb_05_g", 32'(vga_g), 32'h24);
    chk("rgb_05_b", 32'(vga_b), 32'h55);
    goto(570); chk("f1_addr_190", 32'(address2), 19); chk("f1_cs_190", 32'(chipselect2), 1);
    goto(571); chk("f1_cs_200", 32'(chipselect2), 0); chk("f1_addr_200", 32'(address2), 20);
    goto(573); chk("blank_200", 32'(vga_blank_n), 0);
    chk("blank_rgb_zero", {8'h0, vga_r, vga_g, vga_b}, 0);
    goto(580); chk("f1_addr_01", 32'(address2), 20); chk("f1_cs_01", 32'(chipselect2), 1);

    // Horizontal sync edges and width (aligned line 1)
    goto(603); chk("hs_h21", 32'(vga_hs_n), 1);
    goto(604); chk("hs_h22", 32'(vga_hs_n), 0);
    goto(607); chk("hs_h25", 32'(vga_hs_n), 0);
    goto(608); chk("hs_h26", 32'(vga_hs_n), 1);
    n = 0;
    repeat (HT) begin tick(); if (!vga_hs_n) n++; end
    chk("hs_width", 32'(n), 4);

    // Colour patterns
    goto(814); chk("addr_2_9", 32'(address2), 182);
    goto(816);
    chk("rgb_b6_r", 32'(vga_r), 32'hB6);
    chk("rgb_b6_g", 32'(vga_g), 32'hB6);
    chk("rgb_b6_b", 32'(vga_b), 32'hAA);
    goto(914); chk("addr_15_12", 32'(address2), 255);
    goto(916); chk("rgb_ff", {8'h0, vga_r, vga_g, vga_b}, 32'h00FFFFFF);

    // Last pixel and hold
    goto(947); chk("addr_last", 32'(address2), 279); chk("cs_last", 32'(chipselect2), 1);
    goto(948); chk("addr_hold", 32'(address2), 279); chk("cs_after_last", 32'(chipselect2), 0);

    // Vertical sync edges and width
    goto(959);  chk("vs_v14", 32'(vga_vs_n), 1);
    goto(988);  chk("vs_v15", 32'(vga_vs_n), 0);
    goto(1045); chk("vs_v16_end", 32'(vga_vs_n), 0);
    goto(1046); chk("vs_v17", 32'(vga_vs_n), 1);
    n = 0;
    repeat (FRAME) begin tick(); if (!vga_vs_n) n++; end
    chk("vs_width", 32'(n), 2 * HT);

    // Frame period: next frame_start exactly one frame later
    goto(1655); chk("f3_fs", 32'(frame_start), 1);
    n = 0;
    do begin tick(); n++; end while (!frame_start && n < 2 * FRAME);
    chk("frame_period", 32'(n), FRAME);

    // Drop enable mid frame 4: frame 4 completes, frame 5 idles
    goto(2349); enable = 1'b0;
    goto(2600); chk("drop_cs_last", 32'(chipselect2), 1); chk("drop_addr_last", 32'(address2), 279);
    goto(2755); chk("idle_cs00", 32'(chipselect2), 0); chk("idle_addr00", 32'(address2), 0);
    goto(2757); chk("idle_fs", 32'(frame_start), 1); chk("idle_blank", 32'(vga_blank_n), 0);
    n_a = 0;
    while (cyc < 2842) begin tick(); if (chipselect2) n_a++; end
    enable = 1'b1;
    while (cyc < 3305) begin tick(); if (chipselect2) n_a++; end
    chk("idle_cs_count", 32'(n_a), 0);
    goto(3306); chk("rescan_cs00", 32'(chipselect2), 1); chk("rescan_addr00", 32'(address2), 0);
    goto(3308); chk("rescan_blank", 32'(vga_blank_n), 1); chk("rescan_fs", 32'(frame_start), 1);

    // One-cycle reset at (10,8) during a scanned frame
    goto(3548); chk("pre_rst_cs", 32'(chipselect2), 1); chk("pre_rst_addr", 32'(address2), 170);
    reset = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b0;
    cyc = 0;
    chk("post_rst_cs", 32'(chipselect2), 0);
    goto(2); chk("post_rst_fs", 32'(frame_start), 1); chk("post_rst_blank", 32'(vga_blank_n), 0);
    n_a = 0;
    while (cyc < 550) begin tick(); if (chipselect2 || vga_blank_n) n_a++; end
    chk("post_rst_idle_count", 32'(n_a), 0);
    goto(551); chk("post_rst_scan_cs", 32'(chipselect2), 1); chk("post_rst_scan_addr", 32'(address2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
